// File: rtl/cla_pkg.sv
// Shared constants, stage-count helper and per-stage control payload for the
// pipelined carry-lookahead adder.
package cla_pkg;

  localparam int GRP_W = 4;

  function automatic int stages(input int width, input int gps);
    return width / (GRP_W * gps);
  endfunction

  // Control that travels with each beat alongside its data words
  typedef struct packed {
    logic carry;
    logic sub;
  } stage_ctrl_t;

endpackage

// File: rtl/cla_pipe_adder_group.sv
// cla4_group: combinational 4-bit carry-lookahead group. Group P/G are
// exported so stage carries can be formed without waiting on the ripple.
module cla4_group
  import cla_pkg::*;
(
  input  logic [GRP_W-1:0] a,
  input  logic [GRP_W-1:0] b,
  input  logic             ci,
  output logic [GRP_W-1:0] s,
  output logic             co,
  output logic             pg,
  output logic             gg
);

  logic [GRP_W-1:0] g_s;
  logic [GRP_W-1:0] p_s;
  logic [GRP_W-1:0] c_s;

  // Bit generate/propagate, fully expanded lookahead carries and sums
  always_comb begin
    g_s    = a & b;
    p_s    = a ^ b;
    c_s[0] = ci;
    c_s[1] = g_s[0] | (p_s[0] & ci);
    c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & ci);
    c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
           | (p_s[2] & p_s[1] & p_s[0] & ci);
    gg     = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
           | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
    pg     = &p_s;
    co     = gg | (pg & ci);
    s      = p_s ^ c_s;
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder: one GPS-group slice per stage, valid/ready
// back-pressure. Define CLA_PIPE_SUB_EN to add a per-beat subtract input.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GPS   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_PIPE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW     = GRP_W * GPS;
  localparam int STAGES = stages(WIDTH, GPS);

  logic sub_s;
`ifdef CLA_PIPE_SUB_EN
  assign sub_s = sub;
`else
  assign sub_s = 1'b0;
`endif

  logic [STAGES-1:0] vld_q, vld_d, vin_s, ld_s;
  logic [STAGES:0]   en_s;

  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  stage_ctrl_t       ctrl_q [STAGES];
  stage_ctrl_t       ctrl_d [STAGES];
  logic              ovf_q, ovf_d;

  logic [WIDTH-1:0]  a_src_s   [STAGES];
  logic [WIDTH-1:0]  b_src_s   [STAGES];
  logic [WIDTH-1:0]  sum_src_s [STAGES];
  logic              ci_src_s  [STAGES];
  logic              sub_src_s [STAGES];
  logic [SW-1:0]     bx_s      [STAGES];

  logic [GRP_W-1:0]  grp_sum_s [STAGES][GPS];
  logic              grp_ci_s  [STAGES][GPS];
  logic              grp_co_s  [STAGES][GPS];
  logic              grp_p_s   [STAGES][GPS];
  logic              grp_g_s   [STAGES][GPS];

  // Operands seen by each stage: the input port for stage 0, the upstream register otherwise
  always_comb begin
    a_src_s[0]   = a;
    b_src_s[0]   = b;
    sum_src_s[0] = '0;
    ci_src_s[0]  = cin | sub_s;
    sub_src_s[0] = sub_s;
    for (int k = 1; k < STAGES; k++) begin
      a_src_s[k]   = a_q[k-1];
      b_src_s[k]   = b_q[k-1];
      sum_src_s[k] = sum_q[k-1];
      ci_src_s[k]  = ctrl_q[k-1].carry;
      sub_src_s[k] = ctrl_q[k-1].sub;
    end
    for (int k = 0; k < STAGES; k++) begin
      bx_s[k] = b_src_s[k][k*SW +: SW] ^ {SW{sub_src_s[k]}};
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    for (genvar j = 0; j < GPS; j++) begin : g_grp
      cla4_group u_grp (
        .a  (a_src_s[k][k*SW + j*GRP_W +: GRP_W]),
        .b  (bx_s[k][j*GRP_W +: GRP_W]),
        .ci (grp_ci_s[k][j]),
        .s  (grp_sum_s[k][j]),
        .co (grp_co_s[k][j]),
        .pg (grp_p_s[k][j]),
        .gg (grp_g_s[k][j])
      );
    end
  end

  // Group-to-group carry ripple inside each stage, driven by group P/G
  always_comb begin
    logic c_v;
    for (int k = 0; k < STAGES; k++) begin
      c_v = ci_src_s[k];
      for (int j = 0; j < GPS; j++) begin
        grp_ci_s[k][j] = c_v;
        c_v = grp_g_s[k][j] | (grp_p_s[k][j] & c_v);
      end
    end
  end

  // Back-pressure chain: a stage may capture when empty or when its successor moves
  always_comb begin
    en_s[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      en_s[k] = ~vld_q[k] | en_s[k+1];
    end
    vin_s[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      vin_s[k] = vld_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      if (en_s[k]) begin
        vld_d[k] = vin_s[k];
      end else begin
        vld_d[k] = vld_q[k];
      end
      ld_s[k] = en_s[k] & vin_s[k];
    end
  end

  // Data registers only load with a real beat, so a stalled result stays put
  always_comb begin
    ovf_d = ovf_q;
    for (int k = 0; k < STAGES; k++) begin
      a_d[k]    = a_q[k];
      b_d[k]    = b_q[k];
      sum_d[k]  = sum_q[k];
      ctrl_d[k] = ctrl_q[k];
      if (ld_s[k]) begin
        a_d[k]   = a_src_s[k];
        b_d[k]   = b_src_s[k];
        sum_d[k] = sum_src_s[k];
        for (int j = 0; j < GPS; j++) begin
          sum_d[k][k*SW + j*GRP_W +: GRP_W] = grp_sum_s[k][j];
        end
        ctrl_d[k].carry = grp_co_s[k][GPS-1];
        ctrl_d[k].sub   = sub_src_s[k];
      end else begin
        ctrl_d[k] = ctrl_q[k];
      end
    end
    // Carry into the MSB is recovered from its sum bit and effective operands
    if (ld_s[STAGES-1]) begin
      ovf_d = grp_co_s[STAGES-1][GPS-1]
            ^ (grp_sum_s[STAGES-1][GPS-1][GRP_W-1]
               ^ a_src_s[STAGES-1][WIDTH-1]
               ^ bx_s[STAGES-1][SW-1]);
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Pipeline state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        sum_q[k]  <= '0;
        ctrl_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]    <= a_d[k];
        b_q[k]    <= b_d[k];
        sum_q[k]  <= sum_d[k];
        ctrl_q[k] <= ctrl_d[k];
      end
    end
  end

  assign in_ready  = en_s[0];
  assign out_valid = vld_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = ctrl_q[STAGES-1].carry;
  assign ovf       = ovf_q;

endmodule
